uart_tx_arbiter: RTL

//  Shares one uart_send transmitter between two byte requesters (req/ack handshake), round-robin.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Request/grant and transmit-side signals of the two-requester UART arbiter.
// The slave modport is the arbiter; the master modport is the requester/transmitter side.
interface uart_tx_arbiter_if;
    logic       en;
    logic       req0;
    logic [7:0] data0;
    logic       ack0;
    logic       req1;
    logic [7:0] data1;
    logic       ack1;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       busy;
    logic       grant_id;

    modport slave (
        input  en, req0, data0, req1, data1,
        output ack0, ack1, tx_valid, tx_data, busy, grant_id
    );

    modport master (
        output en, req0, data0, req1, data1,
        input  ack0, ack1, tx_valid, tx_data, busy, grant_id
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_send between two byte requesters; paces
// start pulses so successive tx_valid edges are exactly FRAME_CYCLES+GAP_CYCLES apart.
module uart_tx_arbiter #(
    parameter int FRAME_CYCLES = 104161,
    parameter int GAP_CYCLES   = 0
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int          SPACING  = FRAME_CYCLES + GAP_CYCLES;
    localparam logic [19:0] CNT_LAST = 20'(SPACING - 2);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_id_q, grant_id_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        busy_q, busy_d;
    logic        winner;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        tx_valid_d   = 1'b0;
        tx_data_d    = tx_data_q;
        winner       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.en && (bus.req0 || bus.req1)) begin
                    // On a tie the requester that did not win last time is served.
                    winner       = (bus.req0 && bus.req1) ? ~last_grant_q : bus.req1;
                    state_d      = SEND;
                    tx_valid_d   = 1'b1;
                    ack0_d       = ~winner;
                    ack1_d       = winner;
                    tx_data_d    = winner ? bus.data1 : bus.data0;
                    grant_id_d   = winner;
                    last_grant_d = winner;
                    cnt_d        = 20'd0;
                end
            end
            SEND: begin
                state_d = WAIT;
                cnt_d   = 20'd1;
            end
            WAIT: begin
                cnt_d = cnt_q + 20'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 20'd0;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.ack0     = ack0_q;
    assign bus.ack1     = ack1_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.busy     = busy_q;
    assign bus.grant_id = grant_id_q;
endmodule
